sum_accum: RTL and testbench

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum.sv | 133 +++++++++++++
 tb/tb_sum_accum.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// sum_accum: collects COUNT adder sums into one accumulated result per block.
//
// Flow: IDLE takes the first sum of a block, ACCUM adds the remaining ones, and
// HOLD presents the finished total until downstream takes it. Input and output
// handshakes never overlap because in_ready is low while a result is held.
//
// Optional feature: define SUM_ACCUM_SAT_EN to clamp an overflowing block at
// 2^ACC_W-1 instead of wrapping. The ovf flag behaves the same in both builds.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   upstream sum valid
//   in_sum    in   SUM_W-bit sum from the adder stage
//   in_ready  out  block accepts in_sum this cycle (IDLE/ACCUM)
//   out_valid out  accumulated result valid (HOLD)
//   out_ready in   downstream accepts the result
//   out_acc   out  ACC_W-bit total of the last completed block
//   out_ovf   out  block overflowed (only while out_valid)
module sum_accum #(
  parameter int SUM_W = 5,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0]       COUNT_C = 8'(COUNT);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           r_state, w_state_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic [ACC_W-1:0] r_out_acc, w_out_acc_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic             r_ovf, w_ovf_next;

  // Adder datapath: one extra bit so the carry out doubles as the overflow flag.
  logic [ACC_W:0]   w_in_ext;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W-1:0] w_add_res;
  logic [7:0]       w_cnt_inc;
  logic             w_carry;
  logic             w_last;

  // A block starts from zero in IDLE regardless of what acc/cnt hold.
  assign w_acc_base = (r_state == IDLE) ? '0 : r_acc;
  assign w_cnt_inc  = ((r_state == IDLE) ? 8'd0 : r_cnt) + 8'd1;
  assign w_in_ext   = (ACC_W+1)'(in_sum);
  assign w_sum      = {1'b0, w_acc_base} + w_in_ext;
  assign w_carry    = w_sum[ACC_W];
  assign w_last     = (w_cnt_inc == COUNT_C);

`ifdef SUM_ACCUM_SAT_EN
  // Once clamped at max, any later non-zero add carries again, so the
  // value stays pinned at max for the rest of the block.
  assign w_add_res = w_carry ? ACC_MAX : w_sum[ACC_W-1:0];
`else
  assign w_add_res = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_acc <= '0;
    end else begin
      r_state   <= w_state_next;
      r_acc     <= w_acc_next;
      r_cnt     <= w_cnt_next;
      r_ovf     <= w_ovf_next;
      r_out_acc <= w_out_acc_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_acc_next     = r_acc;
    w_cnt_next     = r_cnt;
    w_ovf_next     = r_ovf;
    w_out_acc_next = r_out_acc;
    in_ready       = (r_state != HOLD);
    out_valid      = (r_state == HOLD);
    out_acc        = r_out_acc;
    out_ovf        = (r_state == HOLD) && r_ovf;

    case (r_state)
      IDLE, ACCUM: begin
        if (in_valid) begin
          w_acc_next = w_add_res;
          w_cnt_next = w_cnt_inc;
          w_ovf_next = ((r_state == IDLE) ? 1'b0 : r_ovf) | w_carry;
          if (w_last) begin
            // Result register is loaded here so out_acc survives the
            // clearing of acc at the end of HOLD.
            w_state_next   = HOLD;
            w_out_acc_next = w_add_res;
          end else begin
            w_state_next = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_next = IDLE;
          w_acc_next   = '0;
          w_cnt_next   = '0;
          w_ovf_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sum_accum.sv
module tb_sum_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid  [3];
  logic [4:0] in_sum    [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_acc   [3];
  logic       out_ovf   [3];

  sum_accum #(.SUM_W(5), .ACC_W(8), .COUNT(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_sum(in_sum[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(out_acc[0]), .out_ovf(out_ovf[0]));

  sum_accum #(.SUM_W(5), .ACC_W(8), .COUNT(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_sum(in_sum[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(out_acc[1]), .out_ovf(out_ovf[1]));

  sum_accum #(.SUM_W(5), .ACC_W(8), .COUNT(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_sum(in_sum[2]),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_acc(out_acc[2]), .out_ovf(out_ovf[2]));

  int n_checks = 0;
  int n_passed = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Block-level model: a block is the plain integer total of COUNT accepted
  // sums; the result is that total wrapped (or clamped) to 8 bits.
  int cnt_of   [3] = '{4, 16, 1};
  int m_n      [3];
  int m_total  [3];
  bit m_hold   [3];
  int m_acc    [3];
  bit m_ovf    [3];
  bit m_started = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_started = 1'b1;
        for (int k = 0; k < 3; k++) begin
          m_n[k] = 0; m_total[k] = 0; m_hold[k] = 1'b0; m_acc[k] = 0; m_ovf[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (m_hold[k]) begin
            if (out_ready[k]) m_hold[k] = 1'b0;
          end else if (in_valid[k]) begin
            m_total[k] += int'(in_sum[k]);
            m_n[k]++;
            if (m_n[k] == cnt_of[k]) begin
              m_hold[k] = 1'b1;
              m_ovf[k]  = (m_total[k] > 255);
`ifdef SUM_ACCUM_SAT_EN
              m_acc[k]  = (m_total[k] > 255) ? 255 : m_total[k];
`else
              m_acc[k]  = m_total[k] % 256;
`endif
              m_n[k] = 0;
              m_total[k] = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare plus capture of each presented result.
  int res_acc [3][$];
  int res_ovf [3][$];
  bit prev_valid [3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("in_ready[%0d]", k),  int'(in_ready[k]),  int'(!m_hold[k]));
          chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(m_hold[k]));
          chk($sformatf("out_acc[%0d]", k),   int'(out_acc[k]),   m_acc[k]);
          chk($sformatf("out_ovf[%0d]", k),   int'(out_ovf[k]),   int'(m_hold[k] && m_ovf[k]));
          if (out_valid[k] === 1'b1 && !prev_valid[k]) begin
            res_acc[k].push_back(int'(out_acc[k]));
            res_ovf[k].push_back(int'(out_ovf[k]));
          end
          prev_valid[k] = (out_valid[k] === 1'b1);
        end
      end
    end
  end

  task automatic send(int k, int s);
    bit ok;
    ok = 1'b0;
    in_valid[k] = 1'b1;
    in_sum[k]   = 5'(s);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (in_ready[k] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    in_valid[k] = 1'b0;
    chk($sformatf("accept[%0d]", k), int'(ok), 1);
    $display("send dut%0d sum=%0d accepted=%0d", k, s, ok);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_sum[k] = '0; out_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Four sums of 10 -> 40
    for (int i = 0; i < 4; i++) send(0, 10);
    idle(3);

    // Gapped sums -> 47
    send(0, 15); idle(2); send(0, 0); idle(2); send(0, 31); idle(2); send(0, 1);
    idle(3);

    // Back-pressure on the result for several cycles -> 10
    out_ready[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    idle(6);
    out_ready[0] = 1'b1;
    idle(3);

    // Reset mid-block discards the partial result -> only 20 follows
    send(0, 10); send(0, 10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 5);
    idle(3);

    // Overflowing block with COUNT=16
    for (int i = 0; i < 16; i++) send(1, 31);
    idle(3);

    // COUNT=1: every sum is its own block
    send(2, 7); send(2, 9);
    idle(3);

    // Literal expectations pinning the model
    chk("c4_results", res_acc[0].size(), 4);
    if (res_acc[0].size() == 4) begin
      chk("c4_r0_acc", res_acc[0][0], 40); chk("c4_r0_ovf", res_ovf[0][0], 0);
      chk("c4_r1_acc", res_acc[0][1], 47);
      chk("c4_r2_acc", res_acc[0][2], 10);
      chk("c4_r3_acc", res_acc[0][3], 20);
    end
    chk("c16_results", res_acc[1].size(), 1);
    if (res_acc[1].size() == 1) begin
`ifdef SUM_ACCUM_SAT_EN
      chk("c16_acc", res_acc[1][0], 255);
`else
      chk("c16_acc", res_acc[1][0], 240);
`endif
      chk("c16_ovf", res_ovf[1][0], 1);
    end
    chk("c1_results", res_acc[2].size(), 2);
    if (res_acc[2].size() == 2) begin
      chk("c1_r0_acc", res_acc[2][0], 7);
      chk("c1_r1_acc", res_acc[2][1], 9);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
